// File: rtl/ram_cmd_arbiter.sv
// Purpose : arbitrates two requesters onto the single-port, command-word driven RAM
//           and returns exactly one response per accepted transaction.
// Latency : accept T -> rsp: write hit T+2, write miss T+3, read hit T+3, read miss T+4
//           (with RAM tx_valid one cycle after the read command).
// Backpressure: reqN_ready is a one-cycle accept strobe, only in IDLE; while a transaction
//           is in flight no request is accepted, and there is no preemption.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   reqN_valid/wr/addr/wdata           transaction request from requester N (N = 0, 1)
//   reqN_ready                         accept strobe back to requester N
//   rspN_valid/rdata/err               one-cycle response; rdata/err hold until the next response
//   ram_din, ram_rx_valid              10-bit command word and its strobe to the RAM
//   ram_dout, ram_tx_valid             read data returned by the RAM

module ram_cmd_arbiter #(
    parameter int ADDR_SIZE = 8,   // tied to 8 by the 10-bit RAM command word
    parameter int TIMEOUT   = 4    // WAIT cycles tolerated before a read errors out (>= 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req0_valid,
    input  logic                 req0_wr,
    input  logic [ADDR_SIZE-1:0] req0_addr,
    input  logic [7:0]           req0_wdata,
    output logic                 req0_ready,
    output logic                 rsp0_valid,
    output logic [7:0]           rsp0_rdata,
    output logic                 rsp0_err,

    input  logic                 req1_valid,
    input  logic                 req1_wr,
    input  logic [ADDR_SIZE-1:0] req1_addr,
    input  logic [7:0]           req1_wdata,
    output logic                 req1_ready,
    output logic                 rsp1_valid,
    output logic [7:0]           rsp1_rdata,
    output logic                 rsp1_err,

    output logic [9:0]           ram_din,
    output logic                 ram_rx_valid,
    input  logic [7:0]           ram_dout,
    input  logic                 ram_tx_valid
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // RAM command opcodes (upper two bits of the command word)
    localparam logic [1:0] OP_SET_WADDR = 2'b00;
    localparam logic [1:0] OP_WRITE     = 2'b01;
    localparam logic [1:0] OP_SET_RADDR = 2'b10;
    localparam logic [1:0] OP_READ      = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state_q, state_d;

    // Transaction context latched at accept
    logic                 gnt_q;      // 0 = requester 0 owns the current transaction
    logic                 ptr_q;      // requester favoured when both are valid
    logic                 wr_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [7:0]           wdata_q;

    // Shadows of the RAM's internal address registers; lets a repeated
    // access to the same address skip the set-address command.
    logic                 wsh_vld_q;
    logic [ADDR_SIZE-1:0] wsh_addr_q;
    logic                 rsh_vld_q;
    logic [ADDR_SIZE-1:0] rsh_addr_q;

    logic [CNT_W-1:0]     cnt_q;

    // Per-requester response registers, held between responses
    logic [7:0]           rsp0_rdata_q, rsp1_rdata_q;
    logic                 rsp0_err_q,   rsp1_err_q;

    // ------------------------------------------------------------------
    // Grant selection (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic                 any_vld;
    logic                 accept;
    logic                 gnt_sel;
    logic                 sel_wr;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [7:0]           sel_wdata;
    logic                 hit;

    always_comb begin
        any_vld = req0_valid | req1_valid;
        accept  = (state_q == S_IDLE) && any_vld;

        if (req0_valid && req1_valid) begin
            gnt_sel = ptr_q;
        end else begin
            gnt_sel = req1_valid;
        end

        sel_wr    = gnt_sel ? req1_wr    : req0_wr;
        sel_addr  = gnt_sel ? req1_addr  : req0_addr;
        sel_wdata = gnt_sel ? req1_wdata : req0_wdata;

        // Writes consult the write-address shadow, reads the read-address shadow
        if (sel_wr) begin
            hit = wsh_vld_q && (wsh_addr_q == sel_addr);
        end else begin
            hit = rsh_vld_q && (rsh_addr_q == sel_addr);
        end
    end

    // ------------------------------------------------------------------
    // Result of the transaction, produced on the cycle that leads into RESP
    // ------------------------------------------------------------------
    logic       res_ld;
    logic [7:0] res_rdata;
    logic       res_err;

    always_comb begin
        res_ld    = 1'b0;
        res_rdata = 8'h00;
        res_err   = 1'b0;
        case (state_q)
            S_DATA: begin
                res_ld = wr_q;   // writes complete without RAM feedback
            end
            S_WAIT: begin
                if (ram_tx_valid) begin
                    res_ld    = 1'b1;
                    res_rdata = ram_dout;
                end else if (cnt_q == CNT_LAST) begin
                    res_ld  = 1'b1;
                    res_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_vld) begin
                    state_d = hit ? S_DATA : S_ADDR;
                end
            end
            S_ADDR: state_d = S_DATA;
            S_DATA: state_d = wr_q ? S_RESP : S_WAIT;
            S_WAIT: begin
                if (ram_tx_valid || (cnt_q == CNT_LAST)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction context, shadows and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q      <= 1'b0;
            ptr_q      <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            wsh_vld_q  <= 1'b0;
            wsh_addr_q <= '0;
            rsh_vld_q  <= 1'b0;
            rsh_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_vld) begin
                        gnt_q   <= gnt_sel;
                        ptr_q   <= ~gnt_sel;   // loser gets priority next time
                        wr_q    <= sel_wr;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                    end
                end
                S_ADDR: begin
                    if (wr_q) begin
                        wsh_vld_q  <= 1'b1;
                        wsh_addr_q <= addr_q;
                    end else begin
                        rsh_vld_q  <= 1'b1;
                        rsh_addr_q <= addr_q;
                    end
                end
                S_DATA: begin
                    cnt_q <= '0;
                end
                S_WAIT: begin
                    // Counter saturates at the last value; the FSM leaves WAIT there
                    if (!ram_tx_valid && (cnt_q != CNT_LAST)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response data registers, updated only for the owning requester
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_rdata_q <= 8'h00;
            rsp0_err_q   <= 1'b0;
            rsp1_rdata_q <= 8'h00;
            rsp1_err_q   <= 1'b0;
        end else if (res_ld) begin
            if (gnt_q) begin
                rsp1_rdata_q <= res_rdata;
                rsp1_err_q   <= res_err;
            end else begin
                rsp0_rdata_q <= res_rdata;
                rsp0_err_q   <= res_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        // ready is the only combinational path from inputs; it is forced low
        // while reset is asserted so every output reads 0 during reset.
        req0_ready   = accept && !gnt_sel && rst_n;
        req1_ready   = accept &&  gnt_sel && rst_n;
        ram_rx_valid = 1'b0;
        ram_din      = 10'h000;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        case (state_q)
            S_ADDR: begin
                ram_rx_valid = 1'b1;
                ram_din      = {(wr_q ? OP_SET_WADDR : OP_SET_RADDR), addr_q};
            end
            S_DATA: begin
                ram_rx_valid = 1'b1;
                ram_din      = wr_q ? {OP_WRITE, wdata_q} : {OP_READ, 8'h00};
            end
            S_RESP: begin
                rsp0_valid = !gnt_q;
                rsp1_valid =  gnt_q;
            end
            default: ;
        endcase
    end

    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp0_err   = rsp0_err_q;
    assign rsp1_rdata = rsp1_rdata_q;
    assign rsp1_err   = rsp1_err_q;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Bench for ram_cmd_arbiter: directed scenarios followed by randomized transactions,
// every cycle's outputs compared against a transaction-level reference model.
module tb_ram_cmd_arbiter;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       req0_valid, req0_wr, req0_ready, rsp0_valid, rsp0_err;
    logic [7:0] req0_addr, req0_wdata, rsp0_rdata;
    logic       req1_valid, req1_wr, req1_ready, rsp1_valid, rsp1_err;
    logic [7:0] req1_addr, req1_wdata, rsp1_rdata;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout = 8'h00;
    logic       ram_tx_valid = 1'b0;

    ram_cmd_arbiter #(.ADDR_SIZE(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    typedef struct packed {
        logic       v;
        logic       wr;
        logic [7:0] a;
        logic [7:0] d;
    } req_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [32:0] act;
    assign act = {ram_rx_valid, ram_din, rsp0_valid, rsp1_valid, req0_ready, req1_ready,
                  rsp0_rdata, rsp0_err, rsp1_rdata, rsp1_err};

    // ---------------- RAM environment: executes command words ----------------
    logic [7:0] ram_mem [256];
    logic [7:0] ram_wa = 8'h00;
    logic [7:0] ram_ra = 8'h00;
    int         ram_rem = 0;      // cycles until tx_valid for a pending read
    int         ram_delay = 1;    // 0 = never answer
    bit         ram_init = 1'b0;

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] = 8'((i * 7 + 3) ^ 8'h5A);
            ram_init = 1'b1;
        end
        if (ram_rem != 0) ram_rem--;
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00: ram_wa = ram_din[7:0];
                2'b01: ram_mem[ram_wa] = ram_din[7:0];
                2'b10: ram_ra = ram_din[7:0];
                default: ram_rem = ram_delay;
            endcase
        end
        ram_tx_valid <= (ram_rem == 1);
        ram_dout     <= (ram_rem == 1) ? ram_mem[ram_ra] : 8'($urandom);
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [256];
    int         ptr;          // requester favoured on a tie
    int         last_waddr;   // -1 = unknown
    int         last_raddr;
    logic [7:0] hrd [2];
    logic       herr [2];

    task automatic model_reset();
        ptr = 0; last_waddr = -1; last_raddr = -1;
        hrd[0] = 8'h00; hrd[1] = 8'h00; herr[0] = 1'b0; herr[1] = 1'b0;
    endtask

    function automatic logic [32:0] exp_vec(input logic rx, input logic [9:0] din,
                                            input logic v0, input logic v1,
                                            input logic r0, input logic r1);
        return {rx, din, v0, v1, r0, r1, hrd[0], herr[0], hrd[1], herr[1]};
    endfunction

    function automatic req_t mk(input logic v, input logic wr, input logic [7:0] a, input logic [7:0] d);
        req_t r;
        r.v = v; r.wr = wr; r.a = a; r.d = d;
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.v  = ($urandom_range(0, 2) != 0);
        r.wr = 1'($urandom_range(0, 1));
        r.a  = 8'h40 + 8'($urandom_range(0, 3));
        r.d  = 8'($urandom);
        return r;
    endfunction

    task automatic drive(input req_t r0, input req_t r1);
        req0_valid = r0.v; req0_wr = r0.wr; req0_addr = r0.a; req0_wdata = r0.d;
        req1_valid = r1.v; req1_wr = r1.wr; req1_addr = r1.a; req1_wdata = r1.d;
    endtask

    // One idle cycle offering r0/r1; if something is granted, follow the whole
    // transaction cycle by cycle. abort_k > 0 asserts reset in that cycle.
    task automatic round(input req_t r0, input req_t r1, input int delay, input int abort_k);
        req_t       rr [2];
        int         g, ck, rk;
        bit         miss, wr;
        logic [7:0] a, d, e_rd;
        logic       e_err, rx;
        logic [9:0] din;

        @(posedge clk); #1;
        drive(r0, r1);
        ram_delay = delay;
        @(negedge clk);
        g = -1;
        if (r0.v && r1.v) g = ptr;
        else if (r0.v)    g = 0;
        else if (r1.v)    g = 1;
        chk("accept", act, exp_vec(1'b0, 10'h000, 1'b0, 1'b0, g == 0, g == 1));
        if (g < 0) return;

        rr[0] = r0; rr[1] = r1;
        wr = rr[g].wr; a = rr[g].a; d = rr[g].d;
        ptr = 1 - g;
        if (wr) begin
            miss = (last_waddr != int'(a)); last_waddr = int'(a);
            ref_mem[a] = d; e_rd = 8'h00; e_err = 1'b0;
        end else begin
            miss = (last_raddr != int'(a)); last_raddr = int'(a);
            e_rd  = (delay != 0) ? ref_mem[a] : 8'h00;
            e_err = (delay == 0);
        end
        ck = miss ? 2 : 1;                                   // cycle of the data/read command
        rk = wr ? ck + 1 : ((delay != 0) ? ck + delay + 1 : ck + TO + 1);

        for (int k = 1; k <= rk; k++) begin
            @(posedge clk); #1;
            drive(rnd_req(), rnd_req());                     // must be ignored while busy
            if (k == abort_k) begin
                #1 rst_n = 1'b0;
                #1;
                model_reset();
                chk("arst", act, exp_vec(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0));
                return;
            end
            @(negedge clk);
            if (k == rk) begin
                hrd[g] = e_rd; herr[g] = e_err;
            end
            rx = 1'b0; din = 10'h000;
            if (miss && k == 1) begin
                rx = 1'b1; din = {(wr ? 2'b00 : 2'b10), a};
            end else if (k == ck) begin
                rx = 1'b1; din = wr ? {2'b01, d} : 10'h300;
            end
            chk(wr ? "wr_txn" : "rd_txn", act,
                exp_vec(rx, din, (k == rk) && g == 0, (k == rk) && g == 1, 1'b0, 1'b0));
        end
    endtask

    req_t none;

    initial begin
        int p, dl;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'((i * 7 + 3) ^ 8'h5A);
        model_reset();
        none = mk(1'b0, 1'b0, 8'h00, 8'h00);
        drive(none, none);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset", act, exp_vec(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;

        // write miss, read miss, read hit
        round(mk(1'b1, 1'b1, 8'h12, 8'hA5), none, 1, 0);
        round(mk(1'b1, 1'b0, 8'h12, 8'h00), none, 1, 0);
        round(mk(1'b1, 1'b0, 8'h12, 8'h00), none, 1, 0);
        // both requesters continuously valid: alternating grants
        for (int i = 0; i < 4; i++)
            round(mk(1'b1, 1'b1, 8'h01, 8'h11 + 8'(i)), mk(1'b1, 1'b1, 8'h02, 8'h22 + 8'(i)), 1, 0);
        // write shadow hit then miss
        round(mk(1'b1, 1'b1, 8'h20, 8'h5C), none, 1, 0);
        round(none, mk(1'b1, 1'b1, 8'h20, 8'h6D), 1, 0);
        round(mk(1'b1, 1'b1, 8'h21, 8'h7E), none, 1, 0);
        // read timeout, then a normal read
        round(mk(1'b1, 1'b0, 8'h30, 8'h00), none, 0, 0);
        round(none, mk(1'b1, 1'b0, 8'h12, 8'h00), 1, 0);
        // reset in WAIT: no response, shadows forgotten
        round(mk(1'b1, 1'b0, 8'h21, 8'h00), none, 0, 4);
        drive(none, none);
        repeat (2) begin
            @(negedge clk);
            chk("in_reset", act, exp_vec(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        rst_n = 1'b1;
        repeat (3) round(none, none, 1, 0);
        round(mk(1'b1, 1'b0, 8'h12, 8'h00), none, 1, 0);
        round(mk(1'b1, 1'b1, 8'h21, 8'h99), none, 1, 0);

        // randomized traffic
        repeat (300) begin
            p  = $urandom_range(0, 9);
            dl = (p == 0) ? 0 : ((p < 6) ? 1 : p - 5);
            round(rnd_req(), rnd_req(), dl, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_cmd_arbiter.md
Name: ram_cmd_arbiter

Overview:
- Shares the single-port command-driven RAM between two requesters.
- Takes whole read/write transactions from either requester and translates each into the RAM's 10-bit command words: {00,addr} set write address, {01,data} write, {10,addr} set read address, {11,x} read.
- Collects the read result and returns one response per transaction.
- Sits between the SPI-side/host-side request sources and the RAM's din/rx_valid/dout/tx_valid interface.

Parameters:
- ADDR_SIZE, 8, RAM address width; fixed at 8 because the RAM command word is 10 bits.
- TIMEOUT, 4, number of WAIT cycles allowed for ram_tx_valid before a read is aborted with an error; must be ≥2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a transaction pending.
- req0_wr  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_SIZE  target address.
- req0_wdata  in  8  write data; ignored for reads.
- req0_ready  out  1  single-cycle accept strobe for requester 0.
- rsp0_valid  out  1  one-cycle response strobe for requester 0.
- rsp0_rdata  out  8  read data; 0 for writes and errors.
- rsp0_err  out  1  read timed out; valid with rsp0_valid.
- req1_valid, req1_wr, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata, rsp1_err  same as above, for requester 1.
- ram_din  out  10  command word to RAM.
- ram_rx_valid  out  1  command-word strobe to RAM.
- ram_dout  in  8  RAM read data.
- ram_tx_valid  in  1  RAM read data valid.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0.
  - Round-robin pointer favours requester 0.
  - Write-address and read-address shadow registers invalid.
  - Wait counter 0.
  - Reset mid-transaction discards the transaction; no response is issued.
- Outputs are decoded from registered state and registers only, except reqN_ready, which is combinational in IDLE.
- FSM states: IDLE, ADDR, DATA, WAIT, RESP.
- IDLE:
  - If any reqN_valid is high, grant one requester. If only one is valid, grant it. If both are valid, grant the one the pointer favours.
  - Assert the granted reqN_ready in the same cycle.
  - Latch wr, addr and wdata. Toggle the pointer to the requester that was not granted.
  - Next state is ADDR on a shadow miss, DATA on a shadow hit.
  - A hit means the shadow is valid and equal to addr: the write shadow for writes, the read shadow for reads.
- ADDR:
  - Drive ram_rx_valid=1 and ram_din={00,addr} for a write, {10,addr} for a read.
  - Load the matching shadow with addr and set it valid.
  - Next state DATA.
- DATA:
  - Write: ram_rx_valid=1, ram_din={01,wdata}; next state RESP.
  - Read: ram_rx_valid=1, ram_din={11,8'h00}; clear the wait counter; next state WAIT.
- WAIT:
  - ram_rx_valid=0.
  - If ram_tx_valid=1: capture ram_dout; next state RESP with err=0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without tx_valid, go to RESP with rdata=0 and err=1.
- RESP:
  - Pulse the granted rspN_valid for exactly one cycle with rdata/err. The other rsp stays 0.
  - Next state IDLE.
  - rspN_rdata and rspN_err hold their values until the next response to that requester.
- ram_rx_valid is 0 in IDLE, WAIT and RESP. ram_din is 0 whenever ram_rx_valid=0.
- Latency from the accept cycle T to rsp_valid:
  - Write hit: T+2. Write miss: T+3.
  - Read hit: T+3. Read miss: T+4, given RAM tx_valid one cycle after the {11} command.
- A new request is not accepted until the state returns to IDLE; back-to-back throughput is one transaction per 3–5 cycles.
- Requests are not preempted. reqN_valid may drop at any time before acceptance without effect.

Test Plan:
1. After reset, req0 write addr 8'h12 data 8'hA5 → ram_din=10'h012, then 10'h1A5 on consecutive cycles; rsp0_valid at T+3, rsp0_rdata=0, rsp0_err=0.
2. req0 read addr 8'h12 with the RAM model → ram_din 10'h212 then 10'h300; rsp0_valid at T+4, rdata=8'hA5. A repeat read of 8'h12 skips ADDR: only 10'h300 is sent, response at T+3.
3. req0 and req1 held valid continuously (writes to 8'h01 and 8'h02) → grants alternate 0,1,0,1; each requester receives one rsp per accept; never both rsp_valid high at once.
4. Write 8'h20 twice, then 8'h21 → the second transaction sends only {01,data}; the third sends {00,8'h21} first.
5. Read with ram_tx_valid tied 0, TIMEOUT=4 → rsp_valid after 4 WAIT cycles, rsp_err=1, rsp_rdata=0; the next request proceeds normally.
6. Assert rst_n=0 in WAIT → outputs 0 immediately (asynchronously); no rsp is issued; after release, the first read of a previously used address resends {10,addr} because the shadows are invalid.
